// File: rtl/soc_system_pio_irq_sequencer_pkg.sv
// soc_system_pio_irq_seq_pkg: shared FSM states, CSR/PIO address map and event-word layout
package soc_system_pio_irq_seq_pkg;
  typedef enum logic [2:0] {IDLE, RD_EC, WAIT_EC, RD_DATA, WAIT_DATA, CLR, PUSH} state_e;
  localparam logic [1:0] CSR_EVENT    = 2'd0;
  localparam logic [1:0] CSR_STATUS   = 2'd1;
  localparam logic [1:0] CSR_CTRL     = 2'd2;
  localparam logic [1:0] CSR_SRC_MASK = 2'd3;
  localparam int EV_VALID    = 31;
  localparam int EV_SRC_LSB  = 24;
  localparam int EV_DATA_LSB = 16;
  localparam int ST_OVF      = 8;
  localparam int ST_BUSY     = 9;
  localparam int CTRL_OVF_CLR = 31;
  localparam logic [1:0] PIO_DATA     = 2'd0;
  localparam logic [1:0] PIO_IRQ_MASK = 2'd2;
  localparam logic [1:0] PIO_EDGE_CAP = 2'd3;
  function automatic logic [31:0] make_event(logic [5:0] src, logic [7:0] data, logic [15:0] ts);
    logic [31:0] ev;
    ev = 32'd0;
    ev[EV_VALID] = 1'b1;
    ev[EV_SRC_LSB +: 6] = src;
    ev[EV_DATA_LSB +: 8] = data;
    ev[15:0] = ts;
    return ev;
  endfunction
endpackage

// File: rtl/soc_system_pio_irq_sequencer_if.sv
// soc_system_pio_irq_sequencer_if: PIO master bus and CSR slave bus of the irq sequencer
interface soc_system_pio_irq_sequencer_if #(parameter int N_SRC = 4);
  logic [1:0]         m_address;
  logic [N_SRC-1:0]   m_chipselect;
  logic               m_write_n;
  logic [31:0]        m_writedata;
  logic [32*N_SRC-1:0] m_readdata;
  logic [1:0]         s_address;
  logic               s_chipselect;
  logic               s_read_n;
  logic               s_write_n;
  logic [31:0]        s_writedata;
  logic [31:0]        s_readdata;
  modport master (output m_address, m_chipselect, m_write_n, m_writedata, input m_readdata);
  modport slave (input s_address, s_chipselect, s_read_n, s_write_n, s_writedata, output s_readdata);
endinterface

// File: rtl/soc_system_pio_irq_sequencer_fifo.sv
// soc_system_pio_irq_seq_fifo: synchronous FIFO with count/full/empty and concurrent push+pop
module soc_system_pio_irq_seq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= wdata_i;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= do_push ? wr_q + 1'b1 : wr_q;
      rd_q  <= do_pop ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/soc_system_pio_irq_sequencer.sv
// soc_system_pio_irq_sequencer: round-robin PIO edge-capture servicer logging events into a CPU-drained FIFO
module soc_system_pio_irq_sequencer
  import soc_system_pio_irq_seq_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [N_SRC-1:0]                  src_irq,
  soc_system_pio_irq_sequencer_if.master    pio,
  soc_system_pio_irq_sequencer_if.slave     csr,
  output logic                              irq
);
  localparam int GW = N_SRC > 1 ? $clog2(N_SRC) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_e state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d, rr_gnt;
  logic any_req;
  logic [N_SRC-1:0] req, mask_q, mask_d, cs_q, cs_d;
  logic [1:0] ctrl_q, ctrl_d, addr_q, addr_d;
  logic ovf_q, ovf_d, wn_q, wn_d, irq_q, irq_d;
  logic [31:0] wd_q, wd_d, rdata_q, rdata_d, rd_sel, fifo_rdata, status, event_w;
  logic [15:0] ts_q, ts_ev_q;
  logic [7:0] data_q;
  logic [CW-1:0] count, cnt_nxt;
  logic full, empty, csr_rd, csr_wr, pop, push_req, push, active_d;
  logic [63:0] wd64, mask64;

  assign csr_rd   = csr.s_chipselect & ~csr.s_read_n;
  assign csr_wr   = csr.s_chipselect & ~csr.s_write_n;
  assign pop      = csr_rd && csr.s_address == CSR_EVENT && !empty;
  assign push_req = state_q == PUSH;
  assign push     = push_req && (!full || pop);
  assign cnt_nxt  = count + CW'(push) - CW'(pop);
  assign req      = src_irq & mask_q & {N_SRC{ctrl_q[0]}};
  assign rd_sel   = pio.m_readdata[32*int'(gnt_q) +: 32];
  assign wd64     = {32'd0, csr.s_writedata};
  assign mask64   = 64'(mask_q);
  assign status   = {22'd0, state_q != IDLE, ovf_q, 8'(count)};
  assign event_w  = make_event(6'(gnt_q), data_q, ts_ev_q);

  soc_system_pio_irq_seq_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .push_i(push), .pop_i(pop), .wdata_i(event_w),
    .rdata_o(fifo_rdata), .count_o(count), .full_o(full), .empty_o(empty)
  );

  // search begins one past the previous grant so every source gets a turn
  always_comb begin
    any_req = 1'b0;
    rr_gnt  = gnt_q;
    for (int k = 1; k <= N_SRC; k++) begin
      if (!any_req && req[(int'(gnt_q) + k) % N_SRC]) begin
        any_req = 1'b1;
        rr_gnt  = GW'((int'(gnt_q) + k) % N_SRC);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE:      if (any_req) begin
                   state_d = RD_EC;
                   gnt_d   = rr_gnt;
                 end
      RD_EC:     state_d = WAIT_EC;
      WAIT_EC:   state_d = rd_sel[0] ? RD_DATA : IDLE;
      RD_DATA:   state_d = WAIT_DATA;
      WAIT_DATA: state_d = CLR;
      CLR:       state_d = PUSH;
      PUSH:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // master strobes are decoded from the next state so they are registered yet aligned with it
  always_comb begin
    active_d = state_d inside {RD_EC, RD_DATA, CLR};
    cs_d     = active_d ? N_SRC'(1) << gnt_d : '0;
    addr_d   = !active_d ? 2'd0 : state_d == RD_DATA ? PIO_DATA : PIO_EDGE_CAP;
    wn_d     = state_d != CLR;
    wd_d     = state_d == CLR ? 32'hFFFF_FFFF : 32'd0;
  end

  always_comb begin
    ctrl_d  = csr_wr && csr.s_address == CSR_CTRL ? csr.s_writedata[1:0] : ctrl_q;
    mask_d  = csr_wr && csr.s_address == CSR_SRC_MASK ? wd64[N_SRC-1:0] : mask_q;
    ovf_d   = (push_req && full && !pop) |
              (ovf_q & ~(csr_wr && csr.s_address == CSR_CTRL && csr.s_writedata[CTRL_OVF_CLR]));
    rdata_d = !csr_rd ? rdata_q :
              csr.s_address == CSR_EVENT  ? (empty ? 32'd0 : fifo_rdata) :
              csr.s_address == CSR_STATUS ? status :
              csr.s_address == CSR_CTRL   ? {30'd0, ctrl_q} : mask64[31:0];
    irq_d   = ctrl_d[1] & (cnt_nxt != '0);
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= GW'(N_SRC - 1);
      ctrl_q  <= '0;
      mask_q  <= '0;
      ovf_q   <= 1'b0;
      ts_q    <= '0;
      ts_ev_q <= '0;
      data_q  <= '0;
      cs_q    <= '0;
      addr_q  <= '0;
      wn_q    <= 1'b1;
      wd_q    <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ctrl_q  <= ctrl_d;
      mask_q  <= mask_d;
      ovf_q   <= ovf_d;
      ts_q    <= ts_q + 16'd1;
      ts_ev_q <= state_q == RD_EC ? ts_q : ts_ev_q;
      data_q  <= state_q == WAIT_DATA ? rd_sel[7:0] : data_q;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      wn_q    <= wn_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end

  assign pio.m_chipselect = cs_q;
  assign pio.m_address    = addr_q;
  assign pio.m_write_n    = wn_q;
  assign pio.m_writedata  = wd_q;
  assign csr.s_readdata   = rdata_q;
  assign irq              = irq_q;
endmodule

// File: tb/tb_soc_system_pio_irq_sequencer.sv
// tb_soc_system_pio_irq_sequencer: directed bench with behavioural edge-capture PIOs and CSR host tasks
module tb_soc_system_pio_irq_sequencer;
  import soc_system_pio_irq_seq_pkg::*;
  localparam int N = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0] src_irq, ec, pulse, force_irq;
  logic repulse;
  logic irq;
  logic [31:0] pio_data [N];
  logic [31:0] rd [N];
  logic [15:0] ts;
  int checks = 0, passed = 0, fails = 0;
  int traffic = 0, writes = 0;
  logic [3:0] gq [$];
  logic [31:0] v, exp_ev;
  logic [3:0] exp_g [5];
  int t0;

  soc_system_pio_irq_sequencer_if #(.N_SRC(N)) bus ();
  soc_system_pio_irq_sequencer #(.N_SRC(N), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .src_irq(src_irq), .pio(bus), .csr(bus), .irq(irq)
  );

  always #5 clk = ~clk;

  // edge-capture PIO model: write to EDGE_CAP clears, readdata registered with latency 1
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ec <= '0;
      for (int i = 0; i < N; i++) rd[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.m_chipselect[i] && !bus.m_write_n && bus.m_address == 2'd3) ec[i] <= repulse;
        else if (pulse[i]) ec[i] <= 1'b1;
        rd[i] <= (bus.m_chipselect[i] && bus.m_write_n) ?
                 (bus.m_address == 2'd3 ? {31'd0, ec[i]} : bus.m_address == 2'd0 ? pio_data[i] : 32'd0) : 32'd0;
      end
    end
  for (genvar g = 0; g < N; g++) assign bus.m_readdata[32*g +: 32] = rd[g];
  assign src_irq = ec | force_irq;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) ts <= '0;
    else ts <= ts + 16'd1;

  always @(posedge clk)
    if (reset_n && bus.m_chipselect != '0) begin
      traffic <= traffic + 1;
      if (!bus.m_write_n) writes <= writes + 1;
      if (bus.m_write_n && bus.m_address == 2'd3) gq.push_back(bus.m_chipselect);
    end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.s_address = a; bus.s_chipselect = 1'b1; bus.s_read_n = 1'b0;
    @(negedge clk);
    bus.s_chipselect = 1'b0; bus.s_read_n = 1'b1;
    d = bus.s_readdata;
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.s_address = a; bus.s_writedata = d; bus.s_chipselect = 1'b1; bus.s_write_n = 1'b0;
    @(negedge clk);
    bus.s_chipselect = 1'b0; bus.s_write_n = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_src(input logic [N-1:0] m);
    @(negedge clk); pulse = m;
    @(negedge clk); pulse = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0; repulse = 1'b0; pulse = '0; force_irq = '0;
    cycles(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    bus.s_address = '0; bus.s_chipselect = 1'b0; bus.s_read_n = 1'b1;
    bus.s_write_n = 1'b1; bus.s_writedata = '0;
    pulse = '0; force_irq = '0; repulse = 1'b0;
    pio_data[0] = 32'h0000_0001; pio_data[1] = 32'h0000_00A5;
    pio_data[2] = 32'h0000_003C; pio_data[3] = 32'h0000_0077;
    exp_g = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    cycles(3);
    check("rst_cs", 32'(bus.m_chipselect), 32'h0);
    check("rst_addr", 32'(bus.m_address), 32'h0);
    check("rst_wn", 32'(bus.m_write_n), 32'h1);
    check("rst_wd", bus.m_writedata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_rdata", bus.s_readdata, 32'h0);
    reset_n = 1'b1;
    csr_read(CSR_STATUS, v);   check("rst_status", v, 32'h0);
    csr_read(CSR_CTRL, v);     check("rst_ctrl", v, 32'h0);
    csr_read(CSR_SRC_MASK, v); check("rst_mask", v, 32'h0);

    csr_write(CSR_CTRL, 32'h3);
    csr_write(CSR_SRC_MASK, 32'h1);
    csr_read(CSR_SRC_MASK, v); check("mask_rb", v, 32'h1);
    pulse_src(4'h1);
    step(); exp_ev = 32'h8001_0000 | {16'd0, ts};
    check("c1_cs", 32'(bus.m_chipselect), 32'h1);
    check("c1_addr", 32'(bus.m_address), 32'h3);
    check("c1_wn", 32'(bus.m_write_n), 32'h1);
    step(); check("c2_cs", 32'(bus.m_chipselect), 32'h0);
    step(); check("c3_cs", 32'(bus.m_chipselect), 32'h1);
    check("c3_addr", 32'(bus.m_address), 32'h0);
    step(); step();
    check("c5_cs", 32'(bus.m_chipselect), 32'h1);
    check("c5_addr", 32'(bus.m_address), 32'h3);
    check("c5_wn", 32'(bus.m_write_n), 32'h0);
    check("c5_wd", bus.m_writedata, 32'hFFFF_FFFF);
    step(); check("c6_cs", 32'(bus.m_chipselect), 32'h0);
    check("c6_irq", 32'(irq), 32'h0);
    step(); check("c7_irq", 32'(irq), 32'h1);
    csr_read(CSR_STATUS, v); check("one_status", v, 32'h1);
    csr_read(CSR_EVENT, v);  check("one_event", v, exp_ev);
    csr_read(CSR_EVENT, v);  check("empty_event", v, 32'h0);
    check("irq_after_pop", 32'(irq), 32'h0);

    do_reset();
    gq.delete();
    csr_write(CSR_SRC_MASK, 32'hF);
    repulse = 1'b1;
    pulse = 4'hF;
    csr_write(CSR_CTRL, 32'h1);
    pulse = 4'h0;
    t0 = 0;
    while (gq.size() < 5 && t0 < 200) begin
      @(negedge clk);
      t0++;
    end
    repulse = 1'b0;
    csr_write(CSR_CTRL, 32'h0);
    cycles(10);
    check("fair_cnt", 32'(gq.size() >= 5), 32'h1);
    for (int k = 0; k < 5; k++)
      check($sformatf("fair_g%0d", k), 32'(k < gq.size() ? gq[k] : 4'hX), 32'(exp_g[k]));

    do_reset();
    csr_write(CSR_CTRL, 32'h3);
    csr_write(CSR_SRC_MASK, 32'h1);
    for (int k = 0; k < 9; k++) begin
      pulse_src(4'h1);
      cycles(8);
    end
    csr_read(CSR_STATUS, v); check("ovf_status", v, 32'h108);
    check("ovf_irq", 32'(irq), 32'h1);
    csr_write(CSR_CTRL, 32'h8000_0003);
    csr_read(CSR_STATUS, v); check("ovf_clr_status", v, 32'h8);
    csr_read(CSR_CTRL, v);   check("ctrl_b31_rd0", v, 32'h3);
    csr_read(CSR_EVENT, v);  check("ovf_ev_hdr", v & 32'hFFFF_0000, 32'h8001_0000);
    csr_read(CSR_STATUS, v); check("ovf_pop_status", v, 32'h7);

    do_reset();
    csr_write(CSR_CTRL, 32'h1);
    csr_write(CSR_SRC_MASK, 32'h2);
    gq.delete();
    t0 = writes;
    @(negedge clk); force_irq = 4'h2;
    @(negedge clk); force_irq = 4'h0;
    cycles(6);
    check("spur_writes", 32'(writes - t0), 32'h0);
    check("spur_reads", 32'(gq.size()), 32'h1);
    check("spur_grant", 32'(gq.size() > 0 ? gq[0] : 4'hX), 32'h2);
    csr_read(CSR_STATUS, v); check("spur_status", v, 32'h0);

    do_reset();
    csr_write(CSR_CTRL, 32'h3);
    t0 = traffic;
    pulse_src(4'h4);
    cycles(10);
    check("mask0_traffic", 32'(traffic - t0), 32'h0);
    check("mask0_irq", 32'(irq), 32'h0);
    csr_write(CSR_CTRL, 32'h2);
    csr_write(CSR_SRC_MASK, 32'h4);
    cycles(10);
    check("en0_traffic", 32'(traffic - t0), 32'h0);
    check("en0_irq", 32'(irq), 32'h0);

    do_reset();
    csr_write(CSR_CTRL, 32'h3);
    csr_write(CSR_SRC_MASK, 32'h1);
    pulse_src(4'h1);
    step(); step(); step();
    check("rdd_cs", 32'(bus.m_chipselect), 32'h1);
    check("rdd_addr", 32'(bus.m_address), 32'h0);
    reset_n = 1'b0;
    #1;
    check("arst_cs", 32'(bus.m_chipselect), 32'h0);
    check("arst_wn", 32'(bus.m_write_n), 32'h1);
    check("arst_irq", 32'(irq), 32'h0);
    check("arst_rdata", bus.s_readdata, 32'h0);
    @(negedge clk); reset_n = 1'b1;
    csr_read(CSR_STATUS, v); check("arst_status", v, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
